dlfloat16_writeback: RTL and testbench
======================================

Name: dlfloat16_writeback

Overview:
- Sits directly downstream of the DLFloat16 FPU top, consuming its registered `result[31:0]` and five exception flags.
- Tracks in-flight operations through a fixed-latency tag pipe and buffers completed results in a small FIFO.
- Presents results to the FP/integer register-file write port with a valid/ready handshake.
- Keeps the sticky fflags CSR and throttles issue so the FIFO never overflows.

Parameters:
- LATENCY, 3: cycles from issue accept to result/flags valid at the FPU output; legal range 1..8.
- DEPTH, 4: writeback FIFO entries; power of two, 2..16.
- RD_W, 5: destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  instruction issued to FPU this cycle.
- issue_ready  out  1  writeback can accept another in-flight op.
- issue_rd  in  RD_W  destination register of the issued op.
- issue_to_int  in  1  result targets the integer file (f2i, compare).
- fpu_result  in  32  FPU result; sampled when tag pipe tail is valid.
- fpu_flags  in  5  {invalid, div_by_zero, overflow, underflow, inexact}; sampled with fpu_result.
- wb_valid  out  1  FIFO head valid.
- wb_ready  in  1  register file accepts head.
- wb_rd  out  RD_W  head destination.
- wb_to_int  out  1  head target file.
- wb_data  out  32  head data.
- csr_we  in  1  write fflags.
- csr_wdata  in  5  fflags write value.
- fflags  out  5  sticky accrued flags, same bit order as fpu_flags.

Behaviour:
- Reset: clears tag pipe, FIFO pointers/count, in-flight count and fflags. Reset values: wb_valid=0, wb_rd=0, wb_to_int=0, wb_data=0, fflags=0, issue_ready=1. Reset mid-operation discards all in-flight and buffered results.
- Accept:
  - An issue is accepted when issue_valid && issue_ready.
  - The accept pushes {1, issue_rd, issue_to_int} into stage 0 of a LATENCY-deep tag shift register; otherwise a bubble (valid=0) is pushed.
  - The pipe shifts every cycle and never stalls; the FPU has no stall input.
- Capture:
  - When the tail stage valid=1, the block writes {rd, to_int, fpu_result} into the FIFO in that cycle.
  - In the same cycle, fpu_flags are OR'd into fflags.
  - Results returning with tail valid=0 are ignored, including their flags.
- Credit:
  - inflight = valid tags in the pipe.
  - issue_ready = (fifo_count + inflight) < DEPTH, computed combinationally from registered state.
  - This guarantees a capture never finds the FIFO full; the bench asserts it.
- Pop:
  - wb_valid = (fifo_count != 0). Head fields are driven directly from the FIFO read pointer.
  - wb_valid && wb_ready pops. Head data holds stable while wb_valid && !wb_ready.
- Simultaneous push and pop: count unchanged, both pointers advance; valid for any count including full and empty.
- Pop releases credit with a one-cycle delay: issue_ready reflects the registered count.
- Pointers are log2(DEPTH) bits and wrap naturally. fifo_count is log2(DEPTH)+1 bits.
- fflags next-state priority:
  - csr_we=1: fflags <= csr_wdata | (captured flags this cycle). A same-cycle accrual is never lost.
  - else: fflags <= fflags | captured flags.
- Ordering: strictly in order; results leave in issue order.

Decomposition:
- Shared package dlfloat16_pkg:
  - Flag bit index constants FLG_NV=4, FLG_DZ=3, FLG_OF=2, FLG_UF=1, FLG_NX=0.
  - wb_tag_t struct {valid, rd, to_int}.
  - wb_entry_t struct {rd, to_int, data}.
- Sub-module dlfloat16_wb_fifo: generic synchronous FIFO with push/pop, count, full/empty.
- The tag pipe, credit logic and fflags stay in the top of this block.

Test Plan:
- Reset then single issue (rd=7, to_int=0), with fpu_result=0x0000_3E00 and fpu_flags=0 at cycle +3. Expect wb_valid=1 at cycle +4, wb_rd=7, wb_data=0x0000_3E00; fflags=0.
- Back-to-back 4 issues with wb_ready=0. Expect issue_ready=0 from the cycle after the 4th accept, and a 5th issue_valid not accepted. Raise wb_ready: results pop in order rd=1,2,3,4; issue_ready returns 1 one cycle after the first pop.
- Flag accrual: op A returns flags 5'b00001, op B returns 5'b10000. Expect fflags=5'b10001.
  - csr_we with csr_wdata=0 in the same cycle as op C's capture with flags 5'b00100: expect fflags=5'b00100.
- Bubble flags: drive fpu_flags=5'b11111 with no op in flight. Expect fflags unchanged and FIFO count unchanged.
- Full-FIFO push/pop: FIFO at DEPTH-1 with 1 in flight and wb_ready=1 held, new issue each time credit allows. Expect count stable, no overflow assertion fired, and results in order.
- Reset asserted with 2 in flight and 2 buffered. Expect wb_valid=0, issue_ready=1 and fflags=0 the next cycle; late FPU outputs are not captured.

Source files
------------

// File: rtl/dlfloat16_pkg.sv
// Shared types and constants for the DLFloat16 writeback path: flag bit
// positions, the in-flight tag carried alongside an FPU op, and a FIFO entry.
package dlfloat16_pkg;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // Widest destination index the tag/entry types can carry.
    localparam int WB_RD_W = 5;

    typedef struct packed {
        logic               valid;
        logic [WB_RD_W-1:0] rd;
        logic               to_int;
    } wb_tag_t;

    typedef struct packed {
        logic [WB_RD_W-1:0] rd;
        logic               to_int;
        logic [31:0]        data;
    } wb_entry_t;

endpackage

// File: rtl/dlfloat16_wb_fifo.sv
// Small synchronous FIFO with a combinational head. The head reads as zero
// while empty so the consumer never sees stale or uninitialised storage.
module dlfloat16_wb_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot, so push is legal even when full.
    assign do_push   = push && (!full || do_pop);
    assign count     = count_reg;
    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/dlfloat16_writeback.sv
// Writeback stage behind the fixed-latency DLFloat16 FPU: tags in-flight ops,
// captures results into a FIFO, drives the register-file port and accrues fflags.
module dlfloat16_writeback
    import dlfloat16_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [RD_W-1:0] issue_rd,
    input  logic            issue_to_int,
    input  logic [31:0]     fpu_result,
    input  logic [4:0]      fpu_flags,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_to_int,
    output logic [31:0]     wb_data,
    input  logic            csr_we,
    input  logic [4:0]      csr_wdata,
    output logic [4:0]      fflags
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = 6;

    wb_tag_t            tag_reg [LATENCY];
    wb_tag_t            tag_next;
    wb_tag_t            tail;
    logic [LATENCY-1:0] tag_valid;
    logic [3:0]         inflight;
    logic               issue_accept;
    logic               capture;

    wb_entry_t          push_entry;
    wb_entry_t          head_entry;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    logic [4:0]         cap_flags;
    logic [4:0]         fflags_reg;
    logic [4:0]         fflags_next;

    // Credit covers both buffered and in-flight results, so a capture always finds room.
    assign issue_ready  = !fifo_full &&
                          ((SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(DEPTH));
    assign issue_accept = issue_valid && issue_ready;

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag_valid
            assign tag_valid[gi] = tag_reg[gi].valid;
        end
    endgenerate

    assign inflight = 4'($countones(tag_valid));

    always_comb begin
        tag_next = '0;
        if (issue_accept) begin
            tag_next.valid  = 1'b1;
            tag_next.rd     = WB_RD_W'(issue_rd);
            tag_next.to_int = issue_to_int;
        end
    end

    // The FPU cannot stall, so the tag pipe shifts unconditionally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            tag_reg[0] <= tag_next;
            for (int i = 1; i < LATENCY; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    assign tail       = tag_reg[LATENCY-1];
    assign capture    = tail.valid;
    assign push_entry = '{rd: tail.rd, to_int: tail.to_int, data: fpu_result};

    dlfloat16_wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (push_entry),
        .pop       (wb_ready),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wb_valid  = !fifo_empty;
    assign wb_rd     = RD_W'(head_entry.rd);
    assign wb_to_int = head_entry.to_int;
    assign wb_data   = head_entry.data;

    // Flags from a bubble slot are garbage and must not accrue.
    assign cap_flags[FLG_NV] = capture & fpu_flags[FLG_NV];
    assign cap_flags[FLG_DZ] = capture & fpu_flags[FLG_DZ];
    assign cap_flags[FLG_OF] = capture & fpu_flags[FLG_OF];
    assign cap_flags[FLG_UF] = capture & fpu_flags[FLG_UF];
    assign cap_flags[FLG_NX] = capture & fpu_flags[FLG_NX];

    assign fflags_next = (csr_we ? csr_wdata : fflags_reg) | cap_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_reg <= '0;
        end else begin
            fflags_reg <= fflags_next;
        end
    end

    assign fflags = fflags_reg;

endmodule

// File: tb/tb_dlfloat16_writeback.sv
// Directed bench for dlfloat16_writeback: an FPU model returns results LATENCY
// cycles after issue, and a scoreboard checks every register-file handshake.
module tb_dlfloat16_writeback;

    localparam int LATENCY = 3;
    localparam int DEPTH   = 4;
    localparam int RD_W    = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [RD_W-1:0] issue_rd = '0;
    logic            issue_to_int = 1'b0;
    logic [31:0]     fpu_result = '0;
    logic [4:0]      fpu_flags = '0;
    logic            wb_valid;
    logic            wb_ready = 1'b0;
    logic [RD_W-1:0] wb_rd;
    logic            wb_to_int;
    logic [31:0]     wb_data;
    logic            csr_we = 1'b0;
    logic [4:0]      csr_wdata = '0;
    logic [4:0]      fflags;

    always #5 clk = ~clk;

    dlfloat16_writeback #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH),
        .RD_W    (RD_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_rd     (issue_rd),
        .issue_to_int (issue_to_int),
        .fpu_result   (fpu_result),
        .fpu_flags    (fpu_flags),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_to_int    (wb_to_int),
        .wb_data      (wb_data),
        .csr_we       (csr_we),
        .csr_wdata    (csr_wdata),
        .fflags       (fflags)
    );

    typedef struct {
        logic [RD_W-1:0] rd;
        logic            to_int;
        logic [31:0]     data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic [4:0]  flg;
    } ret_t;

    exp_t        sb_q[$];
    ret_t        pend_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] bubble_result = '0;
    logic [4:0]  bubble_flags = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // FPU model: returns each op's result exactly LATENCY cycles after issue.
    always @(posedge clk) begin
        #1;
        while (pend_q.size() > 0 && pend_q[0].due < cyc) pend_q.delete(0);
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            fpu_result = pend_q[0].res;
            fpu_flags  = pend_q[0].flg;
            pend_q.delete(0);
        end else begin
            fpu_result = bubble_result;
            fpu_flags  = bubble_flags;
        end
    end

    // Monitor: every handshake is compared against the oldest expected result.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut.capture) begin
                checks++;
                if (dut.fifo_full) begin
                    errors++;
                    $display("FAIL overflow: capture with fifo full at cycle %0d", cyc);
                end
            end
            if (wb_valid && wb_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_pop: got rd=%0d int=%0b data=%h expected no result", wb_rd, wb_to_int, wb_data);
                end else begin
                    if (wb_rd !== sb_q[0].rd || wb_to_int !== sb_q[0].to_int || wb_data !== sb_q[0].data) begin
                        errors++;
                        $display("FAIL wb_pop: got rd=%0d int=%0b data=%h expected rd=%0d int=%0b data=%h",
                                 wb_rd, wb_to_int, wb_data, sb_q[0].rd, sb_q[0].to_int, sb_q[0].data);
                    end
                    sb_q.delete(0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [RD_W-1:0] rd, input logic ti, input logic [31:0] res, input logic [4:0] flg);
        chk("issue_ready_at_issue", {31'b0, issue_ready}, 32'd1);
        issue_valid  = 1'b1;
        issue_rd     = rd;
        issue_to_int = ti;
        pend_q.push_back('{due: cyc + LATENCY, res: res, flg: flg});
        sb_q.push_back('{rd: rd, to_int: ti, data: res});
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk("drain_remaining", sb_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) tick();
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("rst_wb_to_int", {31'b0, wb_to_int}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fflags", {27'b0, fflags}, 32'd0);
        chk("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Single op: result visible one cycle after the FPU returns it.
        issue(5'd7, 1'b0, 32'h0000_3E00, 5'b00000);
        repeat (2) tick();
        chk("single_not_early", {31'b0, wb_valid}, 32'd0);
        tick();
        chk("single_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("single_wb_rd", {27'b0, wb_rd}, 32'd7);
        chk("single_wb_data", wb_data, 32'h0000_3E00);
        chk("single_fflags", {27'b0, fflags}, 32'd0);
        wb_ready = 1'b1;
        drain(10);
        wb_ready = 1'b0;

        // Four back-to-back ops exhaust credit while the consumer stalls.
        for (int i = 1; i <= 4; i++) begin
            issue(RD_W'(i), i[0], 32'hA000_0000 + i, 5'b00000);
        end
        chk("credit_exhausted", {31'b0, issue_ready}, 32'd0);
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        tick();
        issue_valid = 1'b0;
        repeat (LATENCY) tick();
        chk("full_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("full_issue_ready", {31'b0, issue_ready}, 32'd0);
        wb_ready = 1'b1;
        chk("ready_during_first_pop", {31'b0, issue_ready}, 32'd0);
        tick();
        chk("ready_after_first_pop", {31'b0, issue_ready}, 32'd1);
        drain(20);

        // Flag accrual, then a CSR write colliding with a capture.
        issue(5'd8, 1'b0, 32'h0000_1111, 5'b00001);
        issue(5'd9, 1'b1, 32'h0000_2222, 5'b10000);
        drain(20);
        chk("fflags_accrue", {27'b0, fflags}, 32'h11);
        issue(5'd10, 1'b0, 32'h0000_3333, 5'b00100);
        repeat (LATENCY - 1) tick();
        csr_we    = 1'b1;
        csr_wdata = 5'b00000;
        tick();
        csr_we = 1'b0;
        chk("fflags_csr_vs_capture", {27'b0, fflags}, 32'h04);
        drain(20);

        // Bubbles carry garbage results and flags that must be ignored.
        bubble_flags  = 5'b11111;
        bubble_result = 32'hDEAD_BEEF;
        repeat (6) tick();
        chk("bubble_fflags", {27'b0, fflags}, 32'h04);
        chk("bubble_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("bubble_count", {29'b0, dut.fifo_count}, 32'd0);
        csr_we    = 1'b1;
        csr_wdata = 5'b01010;
        tick();
        csr_we = 1'b0;
        chk("csr_write", {27'b0, fflags}, 32'h0A);

        // Steady push/pop with the FIFO sitting at DEPTH-1 plus one in flight.
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(RD_W'(16 + i), 1'b1, 32'hB000_0000 + i, 5'b00000);
        end
        repeat (2) tick();
        chk("pp_count_before", {29'b0, dut.fifo_count}, 32'd3);
        chk("pp_ready_before", {31'b0, issue_ready}, 32'd0);
        wb_ready = 1'b1;
        tick();
        chk("pp_count_pushpop", {29'b0, dut.fifo_count}, 32'd3);
        for (int k = 0; k < 10; k++) begin
            if (issue_ready) begin
                issue(RD_W'(20 + k), k[0], 32'hC000_0000 + k, 5'b00000);
            end else begin
                tick();
            end
        end
        drain(40);
        chk("pp_fflags", {27'b0, fflags}, 32'h0A);

        // Reset with two buffered and two in flight discards everything.
        wb_ready = 1'b0;
        issue(5'd24, 1'b0, 32'hD000_0000, 5'b00000);
        issue(5'd25, 1'b1, 32'hD000_0001, 5'b00000);
        repeat (LATENCY + 1) tick();
        chk("rst_mid_buffered", {29'b0, dut.fifo_count}, 32'd2);
        issue(5'd26, 1'b0, 32'hD000_0002, 5'b11111);
        issue(5'd27, 1'b1, 32'hD000_0003, 5'b11111);
        rst = 1'b1;
        sb_q.delete();
        tick();
        rst = 1'b0;
        chk("rst_mid_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_mid_issue_ready", {31'b0, issue_ready}, 32'd1);
        chk("rst_mid_fflags", {27'b0, fflags}, 32'd0);
        wb_ready = 1'b1;
        repeat (LATENCY + 2) tick();
        chk("late_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("late_fflags", {27'b0, fflags}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
